mem_bus_responder: RTL

//  Memory-side responder for the m_bus request/response protocol used by the L1 cache.

---
 rtl/mem_bus_responder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: memory-side responder for the m_bus read protocol.
// Accepts a one-beat read request, waits LATENCY cycles, then returns the
// addressed 64-byte line as 8 beats (ascending from the line base), each beat
// handshaked with respcyc/respack. A backdoor write port preloads the store.
//
// Ports:
//   clk            in   clock, all logic on posedge
//   reset          in   asynchronous active-low reset
//   m_bus_reqcyc   in   read request present
//   m_bus_reqack   out  request accepted (one-cycle pulse)
//   m_bus_req      in   request byte address
//   m_bus_reqtag   in   request tag
//   m_bus_respcyc  out  response beat valid
//   m_bus_respack  in   current beat consumed
//   m_bus_resp     out  response beat data
//   m_bus_resptag  out  tag of the request being answered
//   init_we        in   backdoor write enable
//   init_addr      in   backdoor byte address
//   init_data      in   backdoor write data
module mem_bus_responder #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned MEM_WORDS      = 512,
  parameter int unsigned LATENCY        = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      m_bus_reqcyc,
  output logic                      m_bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] m_bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
  output logic                      m_bus_respcyc,
  input  logic                      m_bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] m_bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag,
  input  logic                      init_we,
  input  logic [BUS_DATA_WIDTH-1:0] init_addr,
  input  logic [BUS_DATA_WIDTH-1:0] init_data
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                    r_state;
  logic [BUS_DATA_WIDTH-1:0] r_mem [MEM_WORDS];
  logic [AW-1:0]             r_base;
  logic [2:0]                r_beat;
  logic [CW-1:0]             r_lat_cnt;
  logic [BUS_TAG_WIDTH-1:0]  r_tag;
  logic                      r_reqack;
  logic                      r_respcyc;
  logic [BUS_DATA_WIDTH-1:0] r_resp;
  logic [BUS_TAG_WIDTH-1:0]  r_resptag;

  logic [AW-1:0] w_req_base;
  logic [AW-1:0] w_wr_idx;
  logic [2:0]    w_beat_nxt;
  logic [AW-1:0] w_rd_cur;
  logic [AW-1:0] w_rd_nxt;
  logic          w_unused;

  // Word index ignores byte offset and aliases above the store depth.
  assign w_req_base = m_bus_req[3 +: AW] & ~AW'(7);
  assign w_wr_idx   = init_addr[3 +: AW];
  assign w_beat_nxt = r_beat + 3'd1;
  assign w_rd_cur   = r_base | AW'(r_beat);
  assign w_rd_nxt   = r_base | AW'(w_beat_nxt);

  assign w_unused = ^{m_bus_req[BUS_DATA_WIDTH-1:AW+3], m_bus_req[2:0],
                      init_addr[BUS_DATA_WIDTH-1:AW+3], init_addr[2:0]};

  // Backing store: backdoor write only, never reset.
  always_ff @(posedge clk) begin
    if (init_we) begin
      r_mem[w_wr_idx] <= init_data;
    end
  end

  // Request/response sequencer with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_beat    <= '0;
      r_lat_cnt <= '0;
      r_tag     <= '0;
      r_reqack  <= 1'b0;
      r_respcyc <= 1'b0;
      r_resp    <= '0;
      r_resptag <= '0;
    end else begin
      r_reqack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (m_bus_reqcyc) begin
            r_base   <= w_req_base;
            r_tag    <= m_bus_reqtag;
            r_reqack <= 1'b1;
            r_state  <= S_ACK;
          end
        end
        S_ACK: begin
          r_beat <= 3'd0;
          if (LATENCY == 0) begin
            r_state   <= S_RESP;
            r_respcyc <= 1'b1;
            r_resp    <= r_mem[r_base];
            r_resptag <= r_tag;
          end else begin
            r_lat_cnt <= CW'(LATENCY);
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Leaving on count 1 puts the first beat LATENCY+1 cycles after reqack.
          if (r_lat_cnt <= CW'(1)) begin
            r_lat_cnt <= '0;
            r_state   <= S_RESP;
            r_respcyc <= 1'b1;
            r_resp    <= r_mem[r_base];
            r_resptag <= r_tag;
          end else begin
            r_lat_cnt <= r_lat_cnt - CW'(1);
          end
        end
        S_RESP: begin
          if (m_bus_respack) begin
            if (r_beat == 3'd7) begin
              r_state   <= S_IDLE;
              r_beat    <= 3'd0;
              r_respcyc <= 1'b0;
              r_resp    <= '0;
              r_resptag <= '0;
            end else begin
              r_beat <= w_beat_nxt;
              r_resp <= r_mem[w_rd_nxt];
            end
          end else begin
            // Re-read the held beat so a backdoor write shows up one cycle later.
            r_resp <= r_mem[w_rd_cur];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_bus_reqack  = r_reqack;
  assign m_bus_respcyc = r_respcyc;
  assign m_bus_resp    = r_resp;
  assign m_bus_resptag = r_resptag;

endmodule
